// File: rtl/wb_result_checker_if.sv
// Core-facing bus of the write-back result checker: register-file write-back
// observation plus the snoop read port used to fetch final register values.
interface wb_result_checker_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic [REG_AW-1:0] rf_raddr;
  logic [XLEN-1:0]   rf_rdata;

  // Core / register-file side.
  modport master (
    output wb_we, wb_rd, wb_data, rf_rdata,
    input  rf_raddr
  );

  // Checker side.
  modport slave (
    input  wb_we, wb_rd, wb_data, rf_rdata,
    output rf_raddr
  );
endinterface

// File: rtl/wb_result_checker.sv
// End-of-program register checker: expected-value table, run timer and sequential
// snoop-read compare. Optional macro WB_NOWRITE_CHECK_EN adds "never written" tracking.
module wb_result_checker #(
  parameter  int NUM_CHECKS     = 8,
  parameter  int XLEN           = 32,
  parameter  int REG_AW         = 5,
  parameter  int TIMEOUT_CYCLES = 256,
  parameter  int CNT_W          = 16,
  localparam int IDX_W          = $clog2(NUM_CHECKS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                exp_wr,
  input  logic [IDX_W-1:0]    exp_idx,
  input  logic [REG_AW-1:0]   exp_reg,
  input  logic [XLEN-1:0]     exp_val,
  input  logic                exp_nowr,
  input  logic                start,
  input  logic                halt,
  wb_result_checker_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timed_out,
  output logic [IDX_W:0]      fail_count,
  output logic [IDX_W-1:0]    first_fail_idx,
  output logic [XLEN-1:0]     first_fail_val,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ISSUE,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHECKS - 1);
  localparam logic [IDX_W:0]   FAIL_SAT  = (IDX_W + 1)'(NUM_CHECKS);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;

  logic [NUM_CHECKS-1:0] tbl_valid;
  logic [REG_AW-1:0]     tbl_reg [NUM_CHECKS];
  logic [XLEN-1:0]       tbl_val [NUM_CHECKS];

  logic table_open;
  logic start_ok;
  logic timeout_hit;

  assign table_open  = (state == S_IDLE) || (state == S_DONE);
  assign start_ok    = table_open && start;
  assign timeout_hit = (cycle_count == TO_LAST);

  // ---------------------------------------------------------------------------
  // Expected-value table
  // ---------------------------------------------------------------------------
  // NOTE: only the valid bits need reset; the payload arrays are qualified by
  // them, so leaving the storage unreset keeps it mappable to plain RAM/LUTs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_valid <= '0;
    end else if (table_open) begin
      if (clear) begin
        tbl_valid <= '0;
      end else if (exp_wr && (int'(exp_idx) < NUM_CHECKS)) begin
        tbl_valid[exp_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (table_open && exp_wr && (int'(exp_idx) < NUM_CHECKS)) begin
      tbl_reg[exp_idx] <= exp_reg;
      tbl_val[exp_idx] <= exp_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional "register must not be written" tracking
  // ---------------------------------------------------------------------------
`ifdef WB_NOWRITE_CHECK_EN
  logic [NUM_CHECKS-1:0]    tbl_nowr;
  logic [2**REG_AW-1:0]     written;

  always_ff @(posedge clk) begin
    if (table_open && exp_wr && (int'(exp_idx) < NUM_CHECKS)) begin
      tbl_nowr[exp_idx] <= exp_nowr;
    end
  end

  // x0 writes are architectural no-ops, so they never mark the register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      written <= '0;
    end else if (start_ok) begin
      written <= '0;
    end else if ((state == S_RUN) && bus.wb_we && (bus.wb_rd != '0)) begin
      written[bus.wb_rd] <= 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^bus.wb_data;
`else
  logic unused_bits;
  assign unused_bits = ^{bus.wb_data, bus.wb_we, bus.wb_rd, exp_nowr};
`endif

  // ---------------------------------------------------------------------------
  // Per-entry compare
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] cur_exp;
  logic            cur_fail;
  logic [IDX_W:0]  fail_count_nx;

  // NOTE: every combinational output gets a default at the top of the block,
  // so no path through the conditionals can leave one unassigned (no latches).
  always_comb begin
    cur_exp       = (tbl_reg[idx] == '0) ? '0 : tbl_val[idx];
    cur_fail      = tbl_valid[idx] && (bus.rf_rdata != cur_exp);
`ifdef WB_NOWRITE_CHECK_EN
    if (tbl_valid[idx] && tbl_nowr[idx] && written[tbl_reg[idx]]) begin
      cur_fail = 1'b1;
    end
`endif
    fail_count_nx = fail_count;
    if (cur_fail && (fail_count != FAIL_SAT)) begin
      fail_count_nx = fail_count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      bus.rf_raddr   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timed_out      <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_val <= '0;
      cycle_count    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_RUN;
            idx            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timed_out      <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_val <= '0;
            cycle_count    <= '0;
          end
        end

        S_RUN: begin
          // Halt beats a coincident timeout; the counter freezes at the end value.
          if (halt || timeout_hit) begin
            state        <= S_ISSUE;
            timed_out    <= !halt;
            idx          <= '0;
            bus.rf_raddr <= tbl_reg[0];
          end else begin
            cycle_count  <= cycle_count + 1'b1;
          end
        end

        S_ISSUE: begin
          // Snoop data for rf_raddr arrives during the following COMPARE cycle.
          state <= S_COMPARE;
        end

        S_COMPARE: begin
          fail_count <= fail_count_nx;
          if (cur_fail && (fail_count == '0)) begin
            first_fail_idx <= idx;
            first_fail_val <= bus.rf_rdata;
          end
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count_nx == '0) && !timed_out;
          end else begin
            state        <= S_ISSUE;
            idx          <= idx + 1'b1;
            bus.rf_raddr <= tbl_reg[idx + 1'b1];
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_result_checker.sv
// Self-checking bench for wb_result_checker: fake core + register file, randomized
// write-back traffic and a behavioural table/register model.
module tb_wb_result_checker;

  localparam int N    = 8;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int TO   = 256;
  localparam int CW   = 16;
  localparam int IW   = $clog2(N);
`ifdef WB_NOWRITE_CHECK_EN
  localparam bit NOWR_EN = 1'b1;
`else
  localparam bit NOWR_EN = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic            clear, exp_wr, exp_nowr, start, halt;
  logic [IW-1:0]   exp_idx;
  logic [AW-1:0]   exp_reg;
  logic [XLEN-1:0] exp_val;
  logic            busy, done, pass, timed_out;
  logic [IW:0]     fail_count;
  logic [IW-1:0]   first_fail_idx;
  logic [XLEN-1:0] first_fail_val;
  logic [CW-1:0]   cycle_count;
  logic            rf_init;

  wb_result_checker_if #(.XLEN(XLEN), .REG_AW(AW)) bus ();

  wb_result_checker #(
    .NUM_CHECKS(N), .XLEN(XLEN), .REG_AW(AW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .exp_wr(exp_wr), .exp_idx(exp_idx),
    .exp_reg(exp_reg), .exp_val(exp_val), .exp_nowr(exp_nowr), .start(start),
    .halt(halt), .bus(bus), .busy(busy), .done(done), .pass(pass),
    .timed_out(timed_out), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_val(first_fail_val), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fake core register file with a one-cycle synchronous snoop read.
  logic [XLEN-1:0] rf [32];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      bus.rf_rdata <= '0;
    end else begin
      if (bus.wb_we && bus.wb_rd != '0) rf[bus.wb_rd] <= bus.wb_data;
      bus.rf_rdata <= (bus.rf_raddr == '0) ? '0 : rf[bus.rf_raddr];
    end
  end

  // Reference model state
  int              n_tests, n_fail;
  logic [XLEN-1:0] m_rf [32];
  bit              m_wr [32];
  bit              t_valid [N];
  int              t_reg [N];
  logic [XLEN-1:0] t_val [N];
  bit              t_nowr [N];
  int              sch_rd [TO];
  logic [XLEN-1:0] sch_data [TO];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int idx, input int rg, input logic [XLEN-1:0] val, input bit nowr);
    exp_wr = 1'b1; exp_idx = IW'(idx); exp_reg = AW'(rg); exp_val = val; exp_nowr = nowr;
    tick();
    exp_wr = 1'b0;
    t_valid[idx] = 1'b1; t_reg[idx] = rg; t_val[idx] = val; t_nowr[idx] = nowr;
  endtask

  task automatic clear_table();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < N; i++) t_valid[i] = 1'b0;
  endtask

  task automatic load_program_table();
    load(0, 14, 35, 1'b0);
    load(1, 15, 51, 1'b0);
    load(2, 16, 15, 1'b0);
    load(3, 17, 51, 1'b0);
    load(4, 18, 3, 1'b0);
    load(5, 19, 0, 1'b1);
  endtask

  // Directed program results plus random noise on x0 and x20..x31.
  task automatic plan(input bit force18, input bit flush19);
    for (int c = 0; c < TO; c++) sch_rd[c] = -1;
    for (int c = 0; c < 16; c++) begin
      if ($urandom_range(1, 0) == 1) begin
        sch_rd[c]   = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(31, 20));
        sch_data[c] = $urandom;
      end
    end
    sch_rd[2]  = 14; sch_data[2]  = 35;
    sch_rd[4]  = 15; sch_data[4]  = 51;
    sch_rd[6]  = 16; sch_data[6]  = 15;
    sch_rd[8]  = 17; sch_data[8]  = 51;
    sch_rd[10] = 18; sch_data[10] = force18 ? 4 : 3;
    if (flush19) begin sch_rd[12] = 19; sch_data[12] = 0; end
  endtask

  function automatic logic [XLEN-1:0] predict(input int rg);
    logic [XLEN-1:0] v;
    v = m_rf[rg];
    for (int c = 0; c < TO; c++) if (sch_rd[c] == rg) v = sch_data[c];
    return (rg == 0) ? '0 : v;
  endfunction

  task automatic run_prog(input int halt_at, input bit disturb, output int end_c, output bit to);
    end_c = -1;
    to    = 1'b0;
    for (int i = 0; i < 32; i++) m_wr[i] = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < TO; c++) begin
      if (sch_rd[c] >= 0) begin
        bus.wb_we = 1'b1; bus.wb_rd = AW'(sch_rd[c]); bus.wb_data = sch_data[c];
        if (sch_rd[c] != 0) begin m_rf[sch_rd[c]] = sch_data[c]; m_wr[sch_rd[c]] = 1'b1; end
      end
      halt = (c == halt_at);
      if (disturb) begin
        exp_wr = (c == 5); exp_idx = '0; exp_reg = 14; exp_val = 999; exp_nowr = 1'b0;
        clear = (c == 6);
        start = (c == 7);
      end
      tick();
      bus.wb_we = 1'b0; halt = 1'b0; exp_wr = 1'b0; clear = 1'b0; start = 1'b0;
      if (c == 3) begin
        check("mid-run cycle_count", 64'(cycle_count), 64'd4);
        check("mid-run busy", 64'(busy), 64'd1);
      end
      if (c == halt_at || c == TO - 1) begin
        end_c = c;
        to    = (c != halt_at);
        break;
      end
    end
  endtask

  task automatic finish_run(input string name, input int end_c, input bit to);
    int fc, fidx, cnt;
    logic [XLEN-1:0] fval, got, want;
    bit ps, bad;
    cnt = 0;
    while (!done && cnt < 4 * N + 8) begin tick(); cnt++; end
    check({name, " latency"}, 64'(cnt), 64'(2 * N));
    fc = 0; fidx = 0; fval = '0;
    for (int i = 0; i < N; i++) begin
      if (t_valid[i]) begin
        want = (t_reg[i] == 0) ? '0 : t_val[i];
        got  = (t_reg[i] == 0) ? '0 : m_rf[t_reg[i]];
        bad  = (got != want) || (NOWR_EN && t_nowr[i] && m_wr[t_reg[i]]);
        if (bad) begin
          if (fc == 0) begin fidx = i; fval = got; end
          fc++;
        end
      end
    end
    ps = (fc == 0) && !to;
    check({name, " pass"}, 64'(pass), 64'(ps));
    check({name, " fail_count"}, 64'(fail_count), 64'(fc));
    check({name, " first_fail_idx"}, 64'(first_fail_idx), 64'(fidx));
    check({name, " first_fail_val"}, 64'(first_fail_val), 64'(fval));
    check({name, " timed_out"}, 64'(timed_out), 64'(to));
    check({name, " cycle_count"}, 64'(cycle_count), 64'(end_c));
    check({name, " busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"}, 64'(busy), 64'd0);
    check({name, " done"}, 64'(done), 64'd0);
    check({name, " pass"}, 64'(pass), 64'd0);
    check({name, " timed_out"}, 64'(timed_out), 64'd0);
    check({name, " fail_count"}, 64'(fail_count), 64'd0);
    check({name, " first_fail_idx"}, 64'(first_fail_idx), 64'd0);
    check({name, " first_fail_val"}, 64'(first_fail_val), 64'd0);
    check({name, " cycle_count"}, 64'(cycle_count), 64'd0);
    check({name, " rf_raddr"}, 64'(bus.rf_raddr), 64'd0);
  endtask

  initial begin
    int  end_c;
    bit  to;
    int  rg;
    n_tests = 0; n_fail = 0;
    reset = 1'b0; clear = 1'b0; exp_wr = 1'b0; exp_idx = '0; exp_reg = '0;
    exp_val = '0; exp_nowr = 1'b0; start = 1'b0; halt = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; rf_init = 1'b1;
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_wr[i] = 1'b0; end
    for (int i = 0; i < N; i++) begin t_valid[i] = 1'b0; t_reg[i] = 0; t_val[i] = '0; t_nowr[i] = 1'b0; end

    // Step 1: reset state
    repeat (2) @(posedge clk);
    #1;
    rf_init = 1'b0;
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Step 2: program table, matching run halted at cycle 20
    load_program_table();
    plan(1'b0, 1'b0);
    run_prog(20, 1'b0, end_c, to);
    finish_run("match", end_c, to);

    // Step 3: x18 corrupted to 4
    plan(1'b1, 1'b0);
    run_prog(20, 1'b0, end_c, to);
    finish_run("x18 wrong", end_c, to);

    // Step 4: flushed branch path writes x19 = 0
    plan(1'b0, 1'b1);
    run_prog(20, 1'b0, end_c, to);
    finish_run("flush x19", end_c, to);

    // Step 5: no halt, timeout
    plan(1'b0, 1'b0);
    run_prog(-1, 1'b0, end_c, to);
    finish_run("timeout", end_c, to);

    // Step 6: halt in the timeout cycle wins
    plan(1'b0, 1'b0);
    run_prog(TO - 1, 1'b0, end_c, to);
    finish_run("halt+timeout", end_c, to);

    // Step 7: table writes, clear and start during RUN are ignored
    plan(1'b0, 1'b0);
    run_prog(20, 1'b1, end_c, to);
    finish_run("disturb", end_c, to);

    // Step 8: clear beats exp_wr in DONE, then empty table passes
    clear = 1'b1; exp_wr = 1'b1; exp_idx = 2; exp_reg = 14; exp_val = 12345; exp_nowr = 1'b0;
    tick();
    clear = 1'b0; exp_wr = 1'b0;
    for (int i = 0; i < N; i++) t_valid[i] = 1'b0;
    plan(1'b1, 1'b0);
    run_prog(20, 1'b0, end_c, to);
    finish_run("empty", end_c, to);

    // Step 9: randomized tables
    for (int k = 0; k < 3; k++) begin
      plan($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
      clear_table();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3, 0) != 0) begin
          rg = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(31, 14));
          load(i, rg, ($urandom_range(1, 0) == 1) ? predict(rg) : (predict(rg) ^ (1 + $urandom_range(255, 0))),
               $urandom_range(1, 0) == 1);
        end
      end
      run_prog(16 + int'($urandom_range(9, 0)), 1'b0, end_c, to);
      finish_run("random", end_c, to);
    end

    // Step 10: async reset during COMPARE loses the table
    clear_table();
    load_program_table();
    plan(1'b1, 1'b0);
    run_prog(20, 1'b0, end_c, to);
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("reset in compare");
    for (int i = 0; i < N; i++) t_valid[i] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    plan(1'b1, 1'b0);
    run_prog(20, 1'b0, end_c, to);
    finish_run("after reset", end_c, to);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
